// File: rtl/jt49_pkg.sv
// Shared definitions for the jt49 host-side bus sequencer.
//  - op_e    : command opcodes carried in cmd_op.
//  - state_e : sequencer FSM states.
//  - AdrW / DataW : PSG register-port widths.
package jt49_pkg;

  localparam int unsigned AdrW  = 4;
  localparam int unsigned DataW = 8;
  localparam int unsigned OpW   = 2;

  typedef enum logic [1:0] {
    OpWrite = 2'd0,
    OpRead  = 2'd1,
    OpDelay = 2'd2,
    OpNop   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StRdWait = 2'd2,
    StDelay  = 2'd3
  } state_e;

endpackage

// File: rtl/jt49_cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through read data.
//  clk_i    : clock, all state on posedge
//  rst_ni   : synchronous active-low reset, empties the FIFO
//  push_i   : write wdata_i (ignored while full)
//  wdata_i  : entry to store
//  pop_i    : discard the head entry (ignored while empty)
//  rdata_o  : head entry, valid while empty_o = 0
//  full_o   : registered, level == Depth
//  empty_o  : registered, level == 0
module jt49_cmd_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 22
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] LevelFull = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Depth is a power of two, so pointers wrap by natural overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop) begin
      level_d = level_q + (PtrW + 1)'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - (PtrW + 1)'(1);
    end
    full_d  = (level_d == LevelFull);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; the empty flag guards stale contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/jt49_bus_seq.sv
// Host-side bus sequencer for the jt49 PSG register port.
// Queues WRITE / READ / DELAY / NOP commands and turns them into PSG strobes
// that are captured on exactly one cen-qualified clock edge.
//  clk_i        : system clock
//  rst_ni       : synchronous active-low reset
//  cen_i        : PSG clock enable (same signal that feeds the jt49)
//  cmd_valid_i  : command offered
//  cmd_ready_o  : command accepted on an edge where valid & ready
//  cmd_op_i     : 0 WRITE, 1 READ, 2 DELAY, 3 NOP
//  cmd_adr_i    : PSG register address
//  cmd_data_i   : WRITE data in [7:0], DELAY tick count
//  rd_valid_o   : one-cycle pulse, rd_data_o updated
//  rd_data_o    : read-back byte, held until the next read
//  psg_adr_o / psg_cs_n_o / psg_wr_n_o / psg_din_o : jt49 register port
//  psg_dout_i   : jt49 data_out
//  busy_o       : commands queued or an access/delay in progress
module jt49_bus_seq
  import jt49_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DLYW  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cen_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [OpW-1:0]   cmd_op_i,
  input  logic [AdrW-1:0]  cmd_adr_i,
  input  logic [DLYW-1:0]  cmd_data_i,
  output logic             rd_valid_o,
  output logic [DataW-1:0] rd_data_o,
  output logic [AdrW-1:0]  psg_adr_o,
  output logic             psg_cs_n_o,
  output logic             psg_wr_n_o,
  output logic [DataW-1:0] psg_din_o,
  input  logic [DataW-1:0] psg_dout_i,
  output logic             busy_o
);

  localparam int unsigned FifoW = OpW + AdrW + DLYW;

  // Command FIFO
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [FifoW-1:0] fifo_rdata;
  op_e              f_op;
  logic [AdrW-1:0]  f_adr;
  logic [DLYW-1:0]  f_data;

  jt49_cmd_fifo #(
    .Depth (DEPTH),
    .Width (FifoW)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmd_valid_i),
    .wdata_i ({cmd_op_i, cmd_adr_i, cmd_data_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign f_op   = op_e'(fifo_rdata[FifoW-1 -: OpW]);
  assign f_adr  = fifo_rdata[DLYW +: AdrW];
  assign f_data = fifo_rdata[DLYW-1:0];

  // Sequencer state and registered outputs
  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [DLYW-1:0]  cnt_q, cnt_d;
  logic [AdrW-1:0]  psg_adr_q, psg_adr_d;
  logic [DataW-1:0] psg_din_q, psg_din_d;
  logic             psg_cs_n_q, psg_cs_n_d;
  logic             psg_wr_n_q, psg_wr_n_d;
  logic             rd_valid_q, rd_valid_d;
  logic [DataW-1:0] rd_data_q, rd_data_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    psg_adr_d  = psg_adr_q;
    psg_din_d  = psg_din_q;
    psg_cs_n_d = psg_cs_n_q;
    psg_wr_n_d = psg_wr_n_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    fifo_pop   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          unique case (f_op)
            OpWrite, OpRead: begin
              op_d       = f_op;
              psg_adr_d  = f_adr;
              psg_din_d  = f_data[DataW-1:0];
              psg_cs_n_d = 1'b0;
              psg_wr_n_d = (f_op != OpWrite);
              state_d    = StIssue;
            end
            OpDelay: begin
              // A zero count is consumed here without any cen wait.
              if (f_data != '0) begin
                cnt_d   = f_data;
                state_d = StDelay;
              end
            end
            default: ;
          endcase
        end
      end

      StIssue: begin
        // The jt49 only samples the port on cen edges; release right after one.
        if (cen_i) begin
          psg_cs_n_d = 1'b1;
          psg_wr_n_d = 1'b1;
          state_d    = (op_q == OpRead) ? StRdWait : StIdle;
        end
      end

      StRdWait: begin
        rd_data_d  = psg_dout_i;
        rd_valid_d = 1'b1;
        state_d    = StIdle;
      end

      StDelay: begin
        if (cen_i) begin
          cnt_d = cnt_q - DLYW'(1);
          if (cnt_q == DLYW'(1)) state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d = ~fifo_empty | (state_q != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      op_q       <= OpNop;
      cnt_q      <= '0;
      psg_adr_q  <= '0;
      psg_din_q  <= '0;
      psg_cs_n_q <= 1'b1;
      psg_wr_n_q <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      psg_adr_q  <= psg_adr_d;
      psg_din_q  <= psg_din_d;
      psg_cs_n_q <= psg_cs_n_d;
      psg_wr_n_q <= psg_wr_n_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
    end
  end

  // Full flag is a flop inside the FIFO, so ready ignores a same-cycle pop.
  assign cmd_ready_o = ~fifo_full;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign psg_adr_o   = psg_adr_q;
  assign psg_cs_n_o  = psg_cs_n_q;
  assign psg_wr_n_o  = psg_wr_n_q;
  assign psg_din_o   = psg_din_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_jt49_bus_seq.sv
// Directed bench for jt49_bus_seq with a small jt49 register-file model.
module tb_jt49_bus_seq;
  import jt49_pkg::*;

  localparam int unsigned DLYW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [3:0]  cmd_adr = '0;
  logic [15:0] cmd_data = '0;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [3:0]  psg_adr;
  logic        psg_cs_n;
  logic        psg_wr_n;
  logic [7:0]  psg_din;
  logic [7:0]  psg_dout;
  logic        busy;

  jt49_bus_seq #(
    .DEPTH (8),
    .DLYW  (DLYW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cen_i       (cen),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_adr_i   (cmd_adr),
    .cmd_data_i  (cmd_data),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (rd_data),
    .psg_adr_o   (psg_adr),
    .psg_cs_n_o  (psg_cs_n),
    .psg_wr_n_o  (psg_wr_n),
    .psg_din_o   (psg_din),
    .psg_dout_i  (psg_dout),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // jt49 register-file model: captures only on edges with cs_n low and cen high.
  logic [7:0]  regs [16];
  logic [11:0] cap_q [$];
  int cen_edges = 0;
  int caps = 0;
  int writes = 0;
  int cs_low = 0;
  int rd_pulses = 0;
  int last_cap_cen = 0;

  assign psg_dout = regs[psg_adr];

  always @(posedge clk) begin
    if (cen) cen_edges <= cen_edges + 1;
    if (!psg_cs_n) cs_low <= cs_low + 1;
    if (rd_valid) rd_pulses <= rd_pulses + 1;
    if (!psg_cs_n && cen) begin
      caps <= caps + 1;
      last_cap_cen <= cen_edges + 1;
      if (!psg_wr_n) begin
        regs[psg_adr] <= psg_din;
        writes <= writes + 1;
        cap_q.push_back({psg_adr, psg_din});
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cen_per = 0;
  int cen_cnt = 0;
  int caps0, writes0, cs0, rd0, snap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cen_cnt++;
    cen = (cen_per != 0) && (cen_cnt % cen_per == 0);
  endtask

  // per = 0: cen stuck low; 1: stuck high; N: high on every Nth edge.
  task automatic set_cen(input int per);
    cen_per = per;
    cen_cnt = 0;
    cen = (per == 1);
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] adr, input logic [15:0] data);
    int guard = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_adr = adr;
    cmd_data = data;
    while (!cmd_ready && guard < 200) begin
      tick();
      guard++;
    end
    check("push_ready", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    tick();
    while (busy && guard < 2000) begin
      tick();
      guard++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    rst_n = 1'b0;
    set_cen(1);
    repeat (3) tick();
    check("rst_cs_n", {31'b0, psg_cs_n}, 32'd1);
    check("rst_wr_n", {31'b0, psg_wr_n}, 32'd1);
    check("rst_adr", {28'b0, psg_adr}, 32'd0);
    check("rst_din", {24'b0, psg_din}, 32'd0);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_rd_data", {24'b0, rd_data}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ready", {31'b0, cmd_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // 1: single write, cen stuck high, cycle-exact strobes
    cs0 = cs_low;
    caps0 = caps;
    push(OpWrite, 4'd7, 16'h0038);
    check("t1_cs_before_pop", {31'b0, psg_cs_n}, 32'd1);
    check("t1_busy_accept", {31'b0, busy}, 32'd0);
    tick();
    check("t1_cs_low", {31'b0, psg_cs_n}, 32'd0);
    check("t1_wr_low", {31'b0, psg_wr_n}, 32'd0);
    check("t1_adr", {28'b0, psg_adr}, 32'd7);
    check("t1_din", {24'b0, psg_din}, 32'h38);
    check("t1_busy_issue", {31'b0, busy}, 32'd1);
    tick();
    check("t1_cs_release", {31'b0, psg_cs_n}, 32'd1);
    check("t1_wr_release", {31'b0, psg_wr_n}, 32'd1);
    check("t1_busy_after_cap", {31'b0, busy}, 32'd1);
    check("t1_reg7", {24'b0, regs[7]}, 32'h38);
    check("t1_adr_held", {28'b0, psg_adr}, 32'd7);
    tick();
    check("t1_busy_fall", {31'b0, busy}, 32'd0);
    check("t1_cs_cycles", cs_low - cs0, 32'd1);
    check("t1_caps", caps - caps0, 32'd1);

    // 2: cen 1-in-16; cs_n held low across 15 edges, one capture on the cen edge
    set_cen(16);
    cs0 = cs_low;
    caps0 = caps;
    push(OpWrite, 4'd0, 16'h005A);
    wait_idle("t2_idle");
    check("t2_caps", caps - caps0, 32'd1);
    check("t2_cs_edges", cs_low - cs0, 32'd15);
    check("t2_reg0", {24'b0, regs[0]}, 32'h5A);

    // 3: write then read back
    set_cen(1);
    rd0 = rd_pulses;
    caps0 = caps;
    writes0 = writes;
    push(OpWrite, 4'd2, 16'h00C3);
    push(OpRead, 4'd2, 16'h0000);
    wait_idle("t3_idle");
    check("t3_rd_pulses", rd_pulses - rd0, 32'd1);
    check("t3_rd_data", {24'b0, rd_data}, 32'hC3);
    check("t3_caps", caps - caps0, 32'd2);
    check("t3_writes", writes - writes0, 32'd1);
    check("t3_rd_valid_low", {31'b0, rd_valid}, 32'd0);

    // 4: DELAY 5 then write, cen every 4th edge
    set_cen(4);
    push(OpDelay, 4'd0, 16'd5);
    tick();
    snap = cen_edges;
    push(OpWrite, 4'd1, 16'h000F);
    wait_idle("t4_idle");
    check("t4_cap_cen_edge", last_cap_cen - snap, 32'd6);
    check("t4_reg1", {24'b0, regs[1]}, 32'h0F);

    // DELAY 0 adds no cen wait
    push(OpDelay, 4'd0, 16'd0);
    push(OpWrite, 4'd1, 16'h001E);
    tick();
    snap = cen_edges;
    wait_idle("t4z_idle");
    check("t4z_cap_cen_edge", last_cap_cen - snap, 32'd1);
    check("t4z_reg1", {24'b0, regs[1]}, 32'h1E);

    // 5: fill with cen low; the first write is held in ISSUE, eight more fill the FIFO
    set_cen(0);
    caps0 = caps;
    cap_q.delete();
    for (int i = 0; i < 9; i++) begin
      push(OpWrite, 4'(i), 16'(32'h10 + i));
    end
    check("t5_ready_full", {31'b0, cmd_ready}, 32'd0);
    check("t5_busy", {31'b0, busy}, 32'd1);
    check("t5_cs_held", {31'b0, psg_cs_n}, 32'd0);
    set_cen(1);
    tick();
    check("t5_ready_before_pop", {31'b0, cmd_ready}, 32'd0);
    tick();
    check("t5_ready_after_pop", {31'b0, cmd_ready}, 32'd1);
    wait_idle("t5_idle");
    check("t5_caps", caps - caps0, 32'd9);
    check("t5_count", cap_q.size(), 32'd9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t5_order%0d", i), {20'b0, cap_q[i]}, 32'((i << 8) | (16 + i)));
    end

    // 6: reset during ISSUE drops the access and the queue
    set_cen(0);
    caps0 = caps;
    push(OpWrite, 4'd5, 16'h0077);
    push(OpWrite, 4'd6, 16'h0066);
    check("t6_cs_low", {31'b0, psg_cs_n}, 32'd0);
    check("t6_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("t6_cs_reset", {31'b0, psg_cs_n}, 32'd1);
    check("t6_wr_reset", {31'b0, psg_wr_n}, 32'd1);
    check("t6_busy_reset", {31'b0, busy}, 32'd0);
    check("t6_ready_reset", {31'b0, cmd_ready}, 32'd1);
    rst_n = 1'b1;
    set_cen(1);
    repeat (4) tick();
    check("t6_busy_after", {31'b0, busy}, 32'd0);
    check("t6_cs_after", {31'b0, psg_cs_n}, 32'd1);
    check("t6_no_capture", caps - caps0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
